// File: rtl/laundromat_pkg.sv
// Shared definitions for the laundromat dispatcher.
//   - mach_state_e : per-machine tracking state (FREE / LOAD / RUN)
//   - F_*          : clock-frequency codes broadcast to the machines
//   - clog2        : ceiling log2 for sizing counters from parameters
package laundromat_pkg;

    typedef enum logic [1:0] {
        M_FREE = 2'd0,
        M_LOAD = 2'd1,
        M_RUN  = 2'd2
    } mach_state_e;

    localparam logic [1:0] F_1MHZ = 2'b00;
    localparam logic [1:0] F_2MHZ = 2'b01;
    localparam logic [1:0] F_4MHZ = 2'b10;
    localparam logic [1:0] F_8MHZ = 2'b11;

    // Smallest r with 2**r >= value; 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/laundromat_dispatcher_req_fifo.sv
// req_fifo: synchronous FIFO holding pending wash requests.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   push_i, din_i     write strobe and data (ignored when full)
//   pop_i             read strobe (ignored when empty)
//   dout_o            head entry, valid while !empty_o
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries (0..DEPTH)
module req_fifo
    import laundromat_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: entries are only read once counted.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/laundromat_dispatcher.sv
// laundromat_dispatcher: queues paid wash requests from the kiosk and hands
// each one to a free washing machine in round-robin order.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid/req_double kiosk request and its double-wash flag
//   req_ready            request FIFO not full
//   cfg_freq / clk_freq  frequency code in, registered broadcast out
//   pause_in / wash_done per-machine lid-open and done flags
//   coin_in, double_wash, timer_pause  per-machine control outputs
//   busy                 machine is in LOAD or RUN
//   grant_valid/grant_id one-cycle dispatch pulse and chosen machine
//   q_count              FIFO occupancy
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high; req_ready depends only on registered state.
module laundromat_dispatcher
    import laundromat_pkg::*;
#(
    parameter int N_MACH    = 4,
    parameter int QDEPTH    = 4,
    parameter int COIN_HOLD = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    input  logic                        req_double,
    output logic                        req_ready,
    input  logic [1:0]                  cfg_freq,
    input  logic [N_MACH-1:0]           pause_in,
    input  logic [N_MACH-1:0]           wash_done,
    output logic [N_MACH-1:0]           coin_in,
    output logic [N_MACH-1:0]           double_wash,
    output logic [N_MACH-1:0]           timer_pause,
    output logic [1:0]                  clk_freq,
    output logic [N_MACH-1:0]           busy,
    output logic                        grant_valid,
    output logic [$clog2(N_MACH)-1:0]   grant_id,
    output logic [$clog2(QDEPTH):0]     q_count
);

    localparam int IW = $clog2(N_MACH);
    localparam int HW = (clog2(COIN_HOLD + 1) < 1) ? 1 : clog2(COIN_HOLD + 1);

    logic              fifo_full, fifo_empty, fifo_head;
    logic              push, do_grant;
    logic [N_MACH-1:0] free_vec, done_rise, done_prev_q;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d, pick_idx, cand;
    logic              pick_found;
    logic [IW-1:0]     grant_id_q;
    logic              grant_valid_q;
    logic [1:0]        clk_freq_q;

    assign push      = req_valid & ~fifo_full;
    assign req_ready = ~fifo_full;
    assign done_rise = wash_done & ~done_prev_q;

    req_fifo #(.WIDTH(1), .DEPTH(QDEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (req_double),
        .pop_i   (do_grant),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (q_count)
    );

    // First FREE machine starting at rr_ptr and wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = 0; off < N_MACH; off++) begin
            cand = IW'((int'(rr_ptr_q) + off) % N_MACH);
            if (!pick_found && free_vec[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign do_grant = pick_found & ~fifo_empty;
    assign rr_ptr_d = do_grant ? IW'((int'(pick_idx) + 1) % N_MACH) : rr_ptr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q      <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            clk_freq_q    <= '0;
            done_prev_q   <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            grant_valid_q <= do_grant;
            clk_freq_q    <= cfg_freq;
            done_prev_q   <= wash_done;
            if (do_grant) grant_id_q <= pick_idx;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign clk_freq    = clk_freq_q;

    for (genvar i = 0; i < N_MACH; i++) begin : g_mach
        mach_state_e   state_q;
        logic [HW-1:0] hold_q;
        logic          coin_q, dbl_q, pause_q;
        logic          grant_here;

        assign grant_here = do_grant && (pick_idx == IW'(i));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= M_FREE;
                hold_q  <= '0;
                coin_q  <= 1'b0;
                dbl_q   <= 1'b0;
                pause_q <= 1'b0;
            end else begin
                case (state_q)
                    M_FREE: begin
                        pause_q <= 1'b0;
                        if (grant_here) begin
                            state_q <= M_LOAD;
                            hold_q  <= '0;
                            coin_q  <= 1'b1;
                            dbl_q   <= fifo_head;
                        end
                    end
                    M_LOAD: begin
                        // Coin strobe stays high for exactly COIN_HOLD cycles.
                        if (hold_q == HW'(COIN_HOLD - 1)) begin
                            state_q <= M_RUN;
                            coin_q  <= 1'b0;
                        end else begin
                            hold_q <= hold_q + HW'(1);
                        end
                    end
                    M_RUN: begin
                        if (done_rise[i]) begin
                            state_q <= M_FREE;
                            dbl_q   <= 1'b0;
                            pause_q <= 1'b0;
                        end else begin
                            pause_q <= pause_in[i];
                        end
                    end
                    default: begin
                        state_q <= M_FREE;
                        coin_q  <= 1'b0;
                        dbl_q   <= 1'b0;
                        pause_q <= 1'b0;
                    end
                endcase
            end
        end

        assign free_vec[i]    = (state_q == M_FREE);
        assign busy[i]        = (state_q == M_LOAD) || (state_q == M_RUN);
        assign coin_in[i]     = coin_q;
        assign double_wash[i] = dbl_q;
        assign timer_pause[i] = pause_q;
    end

endmodule

// File: tb/tb_laundromat_dispatcher.sv
module tb_laundromat_dispatcher;

    logic       clk;
    logic       rst_n;
    logic       req_valid, req_double, req_ready;
    logic [1:0] cfg_freq, clk_freq;
    logic [3:0] pause_in, wash_done, coin_in, double_wash, timer_pause, busy;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic [2:0] q_count;

    int total;
    int bad;

    laundromat_dispatcher #(.N_MACH(4), .QDEPTH(4), .COIN_HOLD(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_double  (req_double),
        .req_ready   (req_ready),
        .cfg_freq    (cfg_freq),
        .pause_in    (pause_in),
        .wash_done   (wash_done),
        .coin_in     (coin_in),
        .double_wash (double_wash),
        .timer_pause (timer_pause),
        .clk_freq    (clk_freq),
        .busy        (busy),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .q_count     (q_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] done_val);
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_double = 1'b0;
        cfg_freq   = 2'b00;
        pause_in   = 4'b0000;
        wash_done  = done_val;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(4'b0000);
        total++; if (req_ready !== 1'b1)     begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        total++; if (q_count !== 3'd0)       begin bad++; $display("FAIL reset_qcount: got %0d want 0", q_count); end
        total++; if (busy !== 4'b0000)       begin bad++; $display("FAIL reset_busy: got %b want 0000", busy); end
        total++; if (coin_in !== 4'b0000)    begin bad++; $display("FAIL reset_coin: got %b want 0000", coin_in); end
        total++; if (grant_valid !== 1'b0)   begin bad++; $display("FAIL reset_gv: got %b want 0", grant_valid); end
        total++; if (grant_id !== 2'd0)      begin bad++; $display("FAIL reset_gid: got %0d want 0", grant_id); end
        total++; if (clk_freq !== 2'b00)     begin bad++; $display("FAIL reset_freq: got %b want 00", clk_freq); end
    endtask

    task automatic test_single();
        do_reset(4'b0000);
        cfg_freq   = 2'b10;
        req_valid  = 1'b1;
        req_double = 1'b1;
        step();  // push
        total++; if (q_count !== 3'd1)       begin bad++; $display("FAIL single_push_q: got %0d want 1", q_count); end
        total++; if (grant_valid !== 1'b0)   begin bad++; $display("FAIL single_nogv: got %b want 0", grant_valid); end
        total++; if (clk_freq !== 2'b10)     begin bad++; $display("FAIL single_freq: got %b want 10", clk_freq); end
        req_valid  = 1'b0;
        req_double = 1'b0;
        step();  // grant
        total++; if (grant_valid !== 1'b1)   begin bad++; $display("FAIL single_gv: got %b want 1", grant_valid); end
        total++; if (grant_id !== 2'd0)      begin bad++; $display("FAIL single_gid: got %0d want 0", grant_id); end
        total++; if (coin_in !== 4'b0001)    begin bad++; $display("FAIL single_coin1: got %b want 0001", coin_in); end
        total++; if (double_wash !== 4'b0001) begin bad++; $display("FAIL single_dw: got %b want 0001", double_wash); end
        total++; if (q_count !== 3'd0)       begin bad++; $display("FAIL single_pop_q: got %0d want 0", q_count); end
        step();
        total++; if (coin_in !== 4'b0001)    begin bad++; $display("FAIL single_coin2: got %b want 0001", coin_in); end
        total++; if (grant_valid !== 1'b0)   begin bad++; $display("FAIL single_gv_pulse: got %b want 0", grant_valid); end
        step();  // now RUN
        total++; if (coin_in !== 4'b0000)    begin bad++; $display("FAIL single_coin_drop: got %b want 0000", coin_in); end
        total++; if (double_wash !== 4'b0001) begin bad++; $display("FAIL single_dw_run: got %b want 0001", double_wash); end
        total++; if (busy !== 4'b0001)       begin bad++; $display("FAIL single_busy_run: got %b want 0001", busy); end
        wash_done = 4'b0001;
        step();
        total++; if (busy !== 4'b0000)       begin bad++; $display("FAIL single_release: got %b want 0000", busy); end
        total++; if (double_wash !== 4'b0000) begin bad++; $display("FAIL single_dw_clear: got %b want 0000", double_wash); end
        wash_done = 4'b0000;
        step();
        total++; if (grant_id !== 2'd0)      begin bad++; $display("FAIL single_gid_hold: got %0d want 0", grant_id); end
    endtask

    task automatic test_back_to_back();
        logic       dbl_tab [5];
        logic [1:0] gid_tab [4];
        dbl_tab = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        gid_tab = '{2'd0, 2'd1, 2'd2, 2'd3};
        do_reset(4'b0000);
        req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_double = dbl_tab[k];
            step();
            if (k > 0) begin
                total++;
                if (grant_valid !== 1'b1 || grant_id !== gid_tab[k-1]) begin
                    bad++;
                    $display("FAIL b2b_grant%0d: got gv=%b id=%0d want gv=1 id=%0d", k-1, grant_valid, grant_id, gid_tab[k-1]);
                end
            end
        end
        req_valid  = 1'b0;
        req_double = 1'b0;
        step();
        total++; if (grant_valid !== 1'b0)   begin bad++; $display("FAIL b2b_nogv: got %b want 0", grant_valid); end
        total++; if (q_count !== 3'd1)       begin bad++; $display("FAIL b2b_queued: got %0d want 1", q_count); end
        total++; if (busy !== 4'b1111)       begin bad++; $display("FAIL b2b_busy: got %b want 1111", busy); end
        total++; if (double_wash !== 4'b1010) begin bad++; $display("FAIL b2b_dw: got %b want 1010", double_wash); end
        step();
        step();
        wash_done = 4'b0100;
        step();
        total++; if (busy !== 4'b1011)       begin bad++; $display("FAIL b2b_free2: got %b want 1011", busy); end
        total++; if (grant_valid !== 1'b0)   begin bad++; $display("FAIL b2b_no_same_cycle: got %b want 0", grant_valid); end
        wash_done = 4'b0000;
        step();
        total++; if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin bad++; $display("FAIL b2b_regrant: got gv=%b id=%0d want gv=1 id=2", grant_valid, grant_id); end
        total++; if (q_count !== 3'd0)       begin bad++; $display("FAIL b2b_drain: got %0d want 0", q_count); end
        total++; if (coin_in !== 4'b0100)    begin bad++; $display("FAIL b2b_coin2: got %b want 0100", coin_in); end
        total++; if (double_wash !== 4'b1110) begin bad++; $display("FAIL b2b_dw2: got %b want 1110", double_wash); end
    endtask

    // Continues from the back-to-back state: all four machines occupied.
    task automatic test_full();
        logic [2:0] cnt_tab [4];
        logic       rdy_tab [4];
        cnt_tab = '{3'd1, 3'd2, 3'd3, 3'd4};
        rdy_tab = '{1'b1, 1'b1, 1'b1, 1'b0};
        req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_double = k[0];
            step();
            total++;
            if (q_count !== cnt_tab[k] || req_ready !== rdy_tab[k]) begin
                bad++;
                $display("FAIL full_fill%0d: got q=%0d rdy=%b want q=%0d rdy=%b", k, q_count, req_ready, cnt_tab[k], rdy_tab[k]);
            end
        end
        step();
        total++; if (q_count !== 3'd4 || req_ready !== 1'b0) begin bad++; $display("FAIL full_ignored: got q=%0d rdy=%b want q=4 rdy=0", q_count, req_ready); end
        wash_done = 4'b0001;
        step();
        total++; if (busy !== 4'b1110)       begin bad++; $display("FAIL full_free0: got %b want 1110", busy); end
        step();  // pop while still full at this edge: push must be refused
        total++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin bad++; $display("FAIL full_grant0: got gv=%b id=%0d want gv=1 id=0", grant_valid, grant_id); end
        total++; if (q_count !== 3'd3)       begin bad++; $display("FAIL full_pop_only: got %0d want 3", q_count); end
        total++; if (req_ready !== 1'b1)     begin bad++; $display("FAIL full_reopen: got %b want 1", req_ready); end
        req_valid = 1'b0;
        wash_done = 4'b0000;
    endtask

    // Continues from test_full: FIFO holds 3, machines in LOAD/RUN.
    task automatic test_reset_mid();
        cfg_freq = 2'b11;
        pause_in = 4'b1111;
        step();
        total++; if (timer_pause !== 4'b1110) begin bad++; $display("FAIL mid_pause_pre: got %b want 1110", timer_pause); end
        rst_n = 1'b0;
        step();
        total++; if (q_count !== 3'd0 || req_ready !== 1'b1) begin bad++; $display("FAIL mid_fifo: got q=%0d rdy=%b want q=0 rdy=1", q_count, req_ready); end
        total++; if ({coin_in, double_wash, timer_pause, busy} !== 16'h0000) begin bad++; $display("FAIL mid_mach: got %h want 0000", {coin_in, double_wash, timer_pause, busy}); end
        total++; if (grant_valid !== 1'b0 || grant_id !== 2'd0 || clk_freq !== 2'b00) begin bad++; $display("FAIL mid_misc: got gv=%b id=%0d f=%b want 0/0/00", grant_valid, grant_id, clk_freq); end
        rst_n    = 1'b1;
        pause_in = 4'b0000;
        cfg_freq = 2'b00;
    endtask

    task automatic test_pause();
        do_reset(4'b0000);
        req_valid = 1'b1;
        step();
        step();
        req_valid = 1'b0;
        step();
        step();
        step();  // machines 0 and 1 both in RUN
        wash_done = 4'b0001;
        step();
        wash_done = 4'b0000;
        pause_in  = 4'b1111;
        total++; if (busy !== 4'b0010)       begin bad++; $display("FAIL pause_only1: got %b want 0010", busy); end
        step();
        total++; if (timer_pause !== 4'b0010) begin bad++; $display("FAIL pause_run1: got %b want 0010", timer_pause); end
        pause_in = 4'b0000;
        step();
        total++; if (timer_pause !== 4'b0000) begin bad++; $display("FAIL pause_clear: got %b want 0000", timer_pause); end
        total++; if (grant_valid !== 1'b0 || grant_id !== 2'd1) begin bad++; $display("FAIL pause_gid_hold: got gv=%b id=%0d want gv=0 id=1", grant_valid, grant_id); end
    endtask

    task automatic test_done_held();
        do_reset(4'b0001);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        total++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin bad++; $display("FAIL held_grant: got gv=%b id=%0d want gv=1 id=0", grant_valid, grant_id); end
        for (int k = 0; k < 4; k++) step();
        total++; if (busy !== 4'b0001)       begin bad++; $display("FAIL held_no_release: got %b want 0001", busy); end
        wash_done = 4'b0000;
        step();
        total++; if (busy !== 4'b0001)       begin bad++; $display("FAIL held_fall: got %b want 0001", busy); end
        wash_done = 4'b0001;
        step();
        total++; if (busy !== 4'b0000)       begin bad++; $display("FAIL held_fresh_edge: got %b want 0000", busy); end
        wash_done = 4'b0000;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_reset_mid();
        test_pause();
        test_done_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
